// File: rtl/servo_pwm_gen_pkg.sv
// Shared types and default timing constants for the servo PWM generator.
// No logic here; latency and backpressure do not apply.
package servo_pkg;
    localparam int PERIOD_CYCLES_DEF = 2_000_000;
    localparam int MIN_PULSE_DEF     = 50_000;
    localparam int MAX_PULSE_DEF     = 250_000;
    localparam int SLEW_STEP_DEF     = 1_000;
    localparam int PWM_W             = 21;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        SLEW = 2'd1,
        HOLD = 2'd2
    } servo_state_t;
endpackage

// File: rtl/servo_pwm_gen_if.sv
// Command/status bundle between the servo sequencer and the PWM generator.
// Pure wiring; no latency, no backpressure (command is level-sampled).
interface servo_pwm_gen_if;
    import servo_pkg::*;

    logic             enable;
    logic [PWM_W-1:0] angle_value;
    logic             pwm_out;
    logic             period_tick;
    logic             settled;
    logic             busy;

    modport master (
        output enable, angle_value,
        input  pwm_out, period_tick, settled, busy
    );

    modport slave (
        input  enable, angle_value,
        output pwm_out, period_tick, settled, busy
    );
endinterface

// File: rtl/servo_pwm_gen_pwm_frame_counter.sv
// Wrapping frame counter, held at zero while disabled; flags frame start and last cycle.
// Outputs decode the counter register directly; no backpressure.
module pwm_frame_counter
    import servo_pkg::*;
#(
    parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    output logic [PWM_W-1:0] o_cnt,
    output logic             o_frame_start,
    output logic             o_period_tick
);
    localparam logic [PWM_W-1:0] LAST = PWM_W'(PERIOD_CYCLES - 1);

    logic [PWM_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_enable || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt         = r_cnt;
    assign o_frame_start = i_enable && (r_cnt == '0);
    assign o_period_tick = (r_cnt == LAST);
endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM: clamps and slew-limits the width command once per frame; outputs registered, 1-cycle latency.
// No backpressure: angle_value is sampled only at frame start, mid-frame changes wait a frame.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF,
    parameter int MIN_PULSE     = MIN_PULSE_DEF,
    parameter int MAX_PULSE     = MAX_PULSE_DEF,
    parameter int SLEW_STEP     = SLEW_STEP_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    servo_pwm_gen_if.slave        io_if
);
    localparam int               XW     = PWM_W + 1;
    localparam logic [XW-1:0]    MIN_W  = XW'(MIN_PULSE);
    localparam logic [XW-1:0]    MAX_W  = XW'(MAX_PULSE);
    localparam logic [XW-1:0]    STEP_W = XW'(SLEW_STEP);

    logic [PWM_W-1:0] w_cnt;
    logic             w_frame_start;
    logic             w_period_tick;

    logic [PWM_W-1:0] r_cur;
    servo_state_t     r_state;
    logic             r_pwm;
    logic             r_settled;
    logic             r_busy;

    logic [XW-1:0]    w_ang, w_cur, w_tgt, w_up, w_dn;
    logic [PWM_W-1:0] w_cur_nxt;
    servo_state_t     w_state_nxt;

    pwm_frame_counter #(
        .PERIOD_CYCLES (PERIOD_CYCLES)
    ) u_frame_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enable      (io_if.enable),
        .o_cnt         (w_cnt),
        .o_frame_start (w_frame_start),
        .o_period_tick (w_period_tick)
    );

    // Extra bit on all width arithmetic so cur/tgt differences cannot wrap.
    always_comb begin
        w_ang       = {1'b0, io_if.angle_value};
        w_cur       = {1'b0, r_cur};
        w_tgt       = w_ang;
        if (w_ang == '0)       w_tgt = '0;
        else if (w_ang < MIN_W) w_tgt = MIN_W;
        else if (w_ang > MAX_W) w_tgt = MAX_W;
        w_up        = w_tgt - w_cur;
        w_dn        = w_cur - w_tgt;
        w_cur_nxt   = r_cur;
        w_state_nxt = r_state;
        if (w_frame_start) begin
            if (w_tgt == '0) begin
                w_state_nxt = OFF;
            end else begin
                if (w_cur == '0)
                    w_cur_nxt = PWM_W'(w_tgt);
                else if (w_tgt >= w_cur)
                    w_cur_nxt = (w_up <= STEP_W) ? PWM_W'(w_tgt) : PWM_W'(w_cur + STEP_W);
                else
                    w_cur_nxt = (w_dn <= STEP_W) ? PWM_W'(w_tgt) : PWM_W'(w_cur - STEP_W);
                w_state_nxt = ({1'b0, w_cur_nxt} == w_tgt) ? HOLD : SLEW;
            end
        end
    end

    // Width is kept across disable so a later command slews from the last position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur     <= '0;
            r_state   <= OFF;
            r_pwm     <= 1'b0;
            r_settled <= 1'b0;
            r_busy    <= 1'b0;
        end else if (!io_if.enable) begin
            r_state   <= OFF;
            r_pwm     <= 1'b0;
            r_settled <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_cur     <= w_cur_nxt;
            r_state   <= w_state_nxt;
            r_pwm     <= (w_state_nxt != OFF) && (w_cnt < w_cur_nxt);
            r_settled <= (w_state_nxt == HOLD);
            r_busy    <= (w_state_nxt == SLEW);
        end
    end

    assign io_if.pwm_out     = r_pwm;
    assign io_if.period_tick = w_period_tick;
    assign io_if.settled     = r_settled;
    assign io_if.busy        = r_busy;
endmodule
